// File: rtl/tiger_muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined multiplier plus iterative restoring divider.
// One op per accepted start; latest accepted op wins, cancel aborts without writing.
module tiger_muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             stall,
  input  logic             cancel,
  input  logic             read_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_rq
);

  localparam int unsigned CW = $clog2(WIDTH + MUL_LATENCY) + 1;
  localparam logic [CW-1:0] MulCnt = CW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
  localparam logic [CW-1:0] DivCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDivIter, StDivFix} state_e;

  state_e state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             accept, acc_mul, acc_div, acc_mthi, acc_mtlo, signed_op;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_res;
  logic             mul_res_v, mul_wr, div_wr, done_q;
  logic [WIDTH-1:0] a_abs, b_abs, rem_q, quo_q, dvs_q, rem_nxt, quo_nxt, q_fix, r_fix;
  logic             dz_q, qneg_q, rneg_q;
  logic [WIDTH:0]   shifted, diff;

  assign accept    = start && !stall && !cancel && (op <= 3'd5);
  assign acc_mul   = accept && (op[2:1] == 2'b00);
  assign acc_div   = accept && (op[2:1] == 2'b01);
  assign acc_mthi  = accept && (op == 3'd4);
  assign acc_mtlo  = accept && (op == 3'd5);
  assign signed_op = !op[0];

  assign a_ext   = {{WIDTH{opa[WIDTH-1] & signed_op}}, opa};
  assign b_ext   = {{WIDTH{opb[WIDTH-1] & signed_op}}, opb};
  assign product = a_ext * b_ext;

  if (MUL_LATENCY > 1) begin : g_pipe
    localparam int unsigned PD = MUL_LATENCY - 1;
    logic [2*WIDTH-1:0] p_q [PD];
    logic [PD-1:0]      v_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
      end else if (cancel || accept) begin
        // Any accept or cancel orphans the older products; only a new mul re-arms stage 0.
        v_q    <= '0;
        v_q[0] <= acc_mul;
      end else begin
        v_q <= v_q << 1;
      end
      p_q[0] <= product;
      for (int i = 1; i < int'(PD); i++) p_q[i] <= p_q[i-1];
    end

    assign mul_res   = p_q[PD-1];
    assign mul_res_v = v_q[PD-1];
  end else begin : g_nopipe
    assign mul_res   = product;
    assign mul_res_v = acc_mul;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (acc_div)                           state_d = StDivIter;
      else if (acc_mul && MUL_LATENCY > 1)   state_d = StMul;
      else                                   state_d = StIdle;
    end else if (cancel) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StMul:     if (cnt_q == '0) state_d = StIdle;
        StDivIter: if (cnt_q == '0) state_d = StDivFix;
        StDivFix:  state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Outputs and write strobes
  always_comb begin
    busy   = (state_q != StIdle);
    mul_wr = 1'b0;
    if (MUL_LATENCY == 1) mul_wr = acc_mul;
    else mul_wr = (state_q == StMul) && (cnt_q == '0) && mul_res_v && !cancel && !accept;
    div_wr = (state_q == StDivFix) && !cancel && !accept;
  end

  assign stall_rq = busy && read_req;
  assign done     = done_q;

  assign a_abs   = (signed_op && opa[WIDTH-1]) ? -opa : opa;
  assign b_abs   = (signed_op && opb[WIDTH-1]) ? -opb : opb;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  // A zero divisor leaves the remainder at |opa|, so negation restores opa itself.
  assign q_fix   = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign r_fix   = rneg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dz_q   <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      if (accept) cnt_q <= acc_div ? DivCnt : MulCnt;
      else if (state_q != StIdle && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (acc_div) begin
        rem_q  <= '0;
        quo_q  <= a_abs;
        dvs_q  <= b_abs;
        dz_q   <= (opb == '0);
        qneg_q <= signed_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        rneg_q <= signed_op && opa[WIDTH-1];
      end else if (state_q == StDivIter) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= mul_wr || div_wr;
      if (acc_mthi) hi <= opa;
      if (acc_mtlo) lo <= opa;
      if (mul_wr) {hi, lo} <= mul_res;
      if (div_wr) begin
        hi <= r_fix;
        lo <= q_fix;
      end
    end
  end

endmodule

// File: tb/tb_tiger_muldiv_unit.sv
// Self-checking bench for tiger_muldiv_unit (WIDTH=32, MUL_LATENCY=5): directed cases
// followed by random ops checked against an arithmetic reference model.
module tb_tiger_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, cancel, read_req;
  logic [2:0]  op;
  logic [31:0] opa, opb, hi, lo;
  logic        busy, done, stall_rq;

  int passed = 0;
  int total  = 0;
  logic [31:0] mhi, mlo;

  tiger_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .stall(stall), .cancel(cancel), .read_req(read_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_rq(stall_rq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", name, obs, exp);
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = 32'd0;
    l = 32'd0;
    case (o)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; h = 32'(sr); l = 32'(sq); end
      end
      3'd3: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endfunction

  // Issue a mul/div, walk every cycle up to its done pulse, and check HI/LO there.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic rr, input logic rand_stall);
    logic [31:0] eh, el;
    int lat;
    model(o, a, b, eh, el);
    lat = (o < 3'd2) ? 5 : 34;
    start = 1'b1; op = o; opa = a; opb = b; read_req = rr;
    tick();
    start = 1'b0;
    for (int c = 1; c < lat; c++) begin
      if (rand_stall) stall = 1'($urandom);
      chk("busy_inflight", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      chk("stall_rq_inflight", 64'(stall_rq), 64'(rr));
      tick();
    end
    stall = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("stall_rq_at_done", 64'(stall_rq), 64'd0);
    chk("hi_result", 64'(hi), 64'(eh));
    chk("lo_result", 64'(lo), 64'(el));
    mhi = eh;
    mlo = el;
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    read_req = 1'b0;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a, input logic stl);
    start = 1'b1; op = o; opa = a; stall = stl;
    tick();
    start = 1'b0; stall = 1'b0;
    if (!stl && o == 3'd4) mhi = a;
    if (!stl && o == 3'd5) mlo = a;
    chk("mt_hi", 64'(hi), 64'(mhi));
    chk("mt_lo", 64'(lo), 64'(mlo));
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
  endtask

  task automatic quiet(input int n, input string name);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (done) pulses++;
      tick();
    end
    chk(name, 64'(pulses), 64'd0);
    chk("quiet_hi", 64'(hi), 64'(mhi));
    chk("quiet_lo", 64'(lo), 64'(mlo));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; cancel = 1'b0; read_req = 1'b1;
    op = 3'd0; opa = '0; opb = '0;
    mhi = '0; mlo = '0;
    tick();
    tick();
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall_rq", 64'(stall_rq), 64'd0);
    reset = 1'b0;
    read_req = 1'b0;
    tick();

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_neg3x5_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("multu_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_neg7_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    chk("divu_100_7_lo", 64'(lo), 64'd14);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_min_m1_lo", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    chk("divu_by0_hi", 64'(hi), 64'd7);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    // Cancel a divide partway through its iterations.
    start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    quiet(40, "cancel_no_done");

    // A multiply accepted mid-divide replaces it.
    start = 1'b1; op = 3'd3; opa = 32'd100; opb = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    run_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("override_lo", 64'(lo), 64'd12);
    quiet(40, "override_no_extra_done");

    mt(3'd5, 32'h1234, 1'b1);
    mt(3'd5, 32'h1234, 1'b0);
    chk("mtlo_value", 64'(lo), 64'h1234);
    mt(3'd4, 32'hCAFE_F00D, 1'b0);
    mt(3'd6, 32'h5555_5555, 1'b0);

    // Cancel beats a same-cycle start.
    start = 1'b1; cancel = 1'b1; op = 3'd4; opa = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_hi", 64'(hi), 64'(mhi));

    // Reset during a multiply.
    start = 1'b1; op = 3'd1; opa = 32'd9; opb = 32'd9;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mhi = '0; mlo = '0;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    quiet(10, "midreset_no_done");

    for (int n = 0; n < 30; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (ro < 3'd4) run_op(ro, ra, rb, 1'($urandom), 1'($urandom));
      else mt(ro, ra, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tiger_muldiv_unit.md
# tiger_muldiv_unit

Parametrised HI/LO multiply/divide unit for the tiger execute stage. It replaces the fixed-latency countdown scheme with an explicit state machine, a configurable-depth multiply pipeline and an iterative restoring divider, generic in operand width. It accepts one operation per start pulse, owns the HI/LO registers, and raises a stall request when a HI/LO read is pending while a result is outstanding. It supports cancellation on pipeline flush.

## Interface
Parameters:
- WIDTH, 32: operand, HI and LO width (>= 8).
- MUL_LATENCY, 5: cycles from accepted MULT/MULTU to HI/LO update (>= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  issue an operation; accepted only when stall=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 ignored (no effect).
- opa  in  WIDTH  rs operand / dividend / move source.
- opb  in  WIDTH  rt operand / divisor.
- stall  in  1  pipeline stall; gates start only.
- cancel  in  1  pipeline clear; kills any in-flight op and any same-cycle start.
- read_req  in  1  MFHI/MFLO present in execute.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO take a mul/div result.
- stall_rq  out  1  busy && read_req (combinational).

## Operation
- States: IDLE, MUL, DIV_ITER, DIV_FIX.
- Accept = start && !stall && !cancel && op<=5.
- MTHI/MTLO: HI (resp. LO) <= opa at the accepting edge. Any in-flight op is aborted; state goes to IDLE.
- MULT/MULTU: operands are sign- or zero-extended to 2*WIDTH and multiplied. The product is carried through a MUL_LATENCY-deep valid-tagged pipeline. State MUL counts down. {HI,LO} <= product on exit.
- DIV/DIVU:
  - Setup edge latches |opa| and |opb| (unsigned ops take them raw), plus sign flags.
  - DIV_ITER runs exactly WIDTH restoring iterations, one quotient bit per cycle.
  - DIV_FIX negates the quotient if the dividend and divisor signs differ, and negates the remainder if the dividend is negative. It then writes LO=quotient, HI=remainder.
- Divide by zero (opb==0, either signedness): LO = all ones, HI = opa. Latency is unchanged.
- Signed MIN / -1: LO = MIN, HI = 0. This falls out of the abs/negate path; no special case is needed.
- Accepted mul/div while busy: the in-flight op is abandoned without writing HI/LO and the new op starts. Latest op wins.
- cancel: state goes to IDLE at the next edge. HI/LO are unchanged, done is not pulsed, and the pipeline valid tags are cleared.
- Ops 6/7: no state change.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, all pipeline valids=0.
- stall_rq = busy && read_req; it is 0 during reset.
- Accept at edge E0 (the edge ending the start cycle).
- MUL: busy is 1 in the MUL_LATENCY-1 cycles after E0; HI/LO are written at edge E0+MUL_LATENCY-1. For MUL_LATENCY=1, HI/LO are written at E0 and busy never rises.
- done is high in the cycle after the HI/LO-writing edge, the same cycle the new hi/lo are visible.
- DIV: busy for WIDTH+1 cycles after E0; HI/LO are written at edge E0+WIDTH+1. For WIDTH=32 that is 33 edges after acceptance.
- MTHI/MTLO: visible the cycle after the accepting edge; busy=0 and done=0.
- A read (MFHI/MFLO) in the cycle where done=1 sees the new value and stall_rq=0.
- stall does not freeze an in-flight op; computation continues during pipeline stalls.
- reset mid-operation: everything returns to reset values at that edge.
- cancel and start in the same cycle: cancel wins and nothing is accepted.

## Test plan
- WIDTH=32, MUL_LATENCY=5, MULT opa=0xFFFFFFFD (-3), opb=5 -> done 5 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV opa=-7, opb=2 -> 33 edges after accept, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU opa=7, opb=0 -> LO=0xFFFFFFFF, HI=7 at normal latency.
- read_req held during a DIV -> stall_rq=1 every busy cycle, 0 in the done cycle, with the correct hi/lo visible.
- Start DIV, cancel at iteration 10 -> busy=0 next cycle, HI/LO keep their prior values, no done pulse. Start DIV, then MULT 3*4 while busy -> only HI=0, LO=12 is written.
- MTLO 0x1234 with stall=1 is ignored. MTLO 0x1234 with stall=0 -> LO=0x1234 next cycle. Assert reset during MUL -> hi=lo=0, busy=0, no done.
